// File: rtl/timer_bank.sv
// timer_bank: bank of independent down-counting timers with a valid/ready load
// port, per-channel cancel, single-cycle expiry pulses and a count readback.
//
// state  | meaning
// S_IDLE | channel stopped, cnt held at 0, never counts or expires
// S_RUN  | channel counting down; expires when cnt reaches 1
module timer_bank #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 2,
  localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load_valid,
  output logic                o_load_ready,
  input  logic [CH_BITS-1:0]  i_load_ch,
  input  logic [WIDTH-1:0]    i_load_value,
  input  logic                i_load_periodic,
  input  logic                i_load_force,
  input  logic [CHANNELS-1:0] i_cancel,
  output logic [CHANNELS-1:0] o_active,
  output logic [CHANNELS-1:0] o_expired,
  input  logic [CH_BITS-1:0]  i_rd_ch,
  output logic [WIDTH-1:0]    o_rd_count
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e                            r_state     [CHANNELS];
  state_e                            w_state_nxt [CHANNELS];
  logic   [CHANNELS-1:0][WIDTH-1:0]  r_cnt;
  logic   [CHANNELS-1:0][WIDTH-1:0]  w_cnt_nxt;
  logic   [CHANNELS-1:0][WIDTH-1:0]  r_rel;
  logic   [CHANNELS-1:0][WIDTH-1:0]  w_rel_nxt;
  logic   [CHANNELS-1:0]             r_per;
  logic   [CHANNELS-1:0]             w_per_nxt;
  logic   [CHANNELS-1:0]             r_expired;
  logic   [CHANNELS-1:0]             w_expired_nxt;
  logic                              w_sel_active;

  // Out-of-range channel selects never match, so they read as idle and are dropped.
  always_comb begin
    w_sel_active = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_load_ch == CH_BITS'(i)) w_sel_active = (r_state[i] == S_RUN);
    end
  end

  assign o_load_ready = !i_rst && (!w_sel_active || i_load_force);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_cnt_nxt[i]     = r_cnt[i];
      w_rel_nxt[i]     = r_rel[i];
      w_per_nxt[i]     = r_per[i];
      w_expired_nxt[i] = 1'b0;
      if (i_load_valid && o_load_ready && (i_load_ch == CH_BITS'(i))) begin
        if (i_load_value != '0) begin
          w_state_nxt[i] = S_RUN;
          w_cnt_nxt[i]   = i_load_value;
          w_rel_nxt[i]   = i_load_value;
          w_per_nxt[i]   = i_load_periodic;
        end else begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      end else if (i_cancel[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end else if (r_state[i] == S_RUN) begin
        if (r_cnt[i] > WIDTH'(1)) begin
          w_cnt_nxt[i] = r_cnt[i] - WIDTH'(1);
        end else if (r_cnt[i] == WIDTH'(1)) begin
          w_expired_nxt[i] = 1'b1;
          if (r_per[i]) begin
            w_cnt_nxt[i] = r_rel[i];
          end else begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < CHANNELS; i++) r_state[i] <= S_IDLE;
      r_cnt     <= '0;
      r_rel     <= '0;
      r_per     <= '0;
      r_expired <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) r_state[i] <= w_state_nxt[i];
      r_cnt     <= w_cnt_nxt;
      r_rel     <= w_rel_nxt;
      r_per     <= w_per_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_comb begin
    o_active   = '0;
    o_rd_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      o_active[i] = (r_state[i] == S_RUN);
      if (i_rd_ch == CH_BITS'(i)) o_rd_count = r_cnt[i];
    end
  end

  assign o_expired = r_expired;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed stimulus against a time-based model of the timers
// (expiry/count derived from accept edge, period and mode), checked every cycle.
module tb_timer_bank;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [CB-1:0] ld_ch = '0;
  logic [W-1:0]  ld_value = '0;
  logic          ld_per = 1'b0;
  logic          ld_force = 1'b0;
  logic [CH-1:0] cancel = '0;
  logic [CH-1:0] active;
  logic [CH-1:0] expired;
  logic [CB-1:0] rd_ch = '0;
  logic [W-1:0]  rd_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  timer_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_valid(ld_valid), .o_load_ready(ld_ready),
    .i_load_ch(ld_ch), .i_load_value(ld_value), .i_load_periodic(ld_per),
    .i_load_force(ld_force), .i_cancel(cancel), .o_active(active),
    .o_expired(expired), .i_rd_ch(rd_ch), .o_rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Model: a channel is described by its accept edge, period and mode.
  int n = 0;
  bit m_run [CH];
  bit m_per [CH];
  int m_t0  [CH];
  int m_v   [CH];
  bit m_rdy;

  function automatic bit f_active(int ch);
    if (ch >= CH || !m_run[ch]) return 1'b0;
    if (m_per[ch]) return 1'b1;
    return (n - m_t0[ch]) < m_v[ch];
  endfunction

  function automatic int f_cnt(int ch);
    int k;
    if (!f_active(ch)) return 0;
    k = n - m_t0[ch];
    return m_per[ch] ? m_v[ch] - (k % m_v[ch]) : m_v[ch] - k;
  endfunction

  function automatic bit f_exp(int ch);
    int k;
    if (!m_run[ch]) return 1'b0;
    k = n - m_t0[ch];
    if (k <= 0) return 1'b0;
    return m_per[ch] ? (k % m_v[ch] == 0) : (k == m_v[ch]);
  endfunction

  function automatic bit f_ready();
    return !rst && (int'(ld_ch) >= CH || !f_active(int'(ld_ch)) || ld_force);
  endfunction

  always @(posedge clk) begin
    m_rdy = f_ready();
    n = n + 1;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_run[c] = 1'b0;
      end else if (ld_valid && m_rdy && int'(ld_ch) == c) begin
        m_run[c] = (ld_value != 0);
        m_t0[c]  = n;
        m_v[c]   = int'(ld_value);
        m_per[c] = ld_per;
      end else if (cancel[c]) begin
        m_run[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      for (int c = 0; c < CH; c++) begin
        if (active[c] !== f_active(c)) begin
          miscompares++;
          $display("FAIL active[%0d] at edge %0d: got %b want %b", c, n, active[c], f_active(c));
        end
        if (expired[c] !== f_exp(c)) begin
          miscompares++;
          $display("FAIL expired[%0d] at edge %0d: got %b want %b", c, n, expired[c], f_exp(c));
        end
      end
      if (rd_count !== W'(f_cnt(int'(rd_ch)))) begin
        miscompares++;
        $display("FAIL rd_count ch%0d at edge %0d: got %0d want %0d", rd_ch, n, rd_count, f_cnt(int'(rd_ch)));
      end
      if (ld_ready !== f_ready()) begin
        miscompares++;
        $display("FAIL load_ready at edge %0d: got %b want %b", n, ld_ready, f_ready());
      end
    end
  end

  task automatic lit(string name, int got, int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(int ch, int v, bit per, bit frc);
    ld_valid = 1'b1;
    ld_ch    = CB'(ch);
    ld_value = W'(v);
    ld_per   = per;
    ld_force = frc;
  endtask

  task automatic clr();
    ld_valid = 1'b0;
    ld_value = '0;
    ld_per   = 1'b0;
    ld_force = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk_en = 1'b1;
    lit("rst_active", int'(active), 0);
    lit("rst_expired", int'(expired), 0);
    lit("rst_rd_count", int'(rd_count), 0);
    lit("rst_ready", int'(ld_ready), 0);
    rst = 1'b0;
    step();

    // one-shot ch0 V=5
    ld(0, 5, 1'b0, 1'b0);
    #1 lit("os_ready", int'(ld_ready), 1);
    step();
    clr();
    lit("os_cnt0", int'(rd_count), 5);
    lit("os_act0", int'(active[0]), 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      lit("os_cnt", int'(rd_count), 5 - k);
      lit("os_model_cnt", f_cnt(0), 5 - k);
      lit("os_exp", int'(expired[0]), (k == 5) ? 1 : 0);
      lit("os_act", int'(active[0]), (k < 5) ? 1 : 0);
    end

    // periodic ch1 V=3
    ld(1, 3, 1'b1, 1'b0);
    rd_ch = 1;
    step();
    clr();
    for (int k = 1; k <= 10; k++) begin
      step();
      lit("per_exp", int'(expired[1]), (k % 3 == 0) ? 1 : 0);
      lit("per_act", int'(active[1]), 1);
      lit("per_cnt", int'(rd_count), 3 - (k % 3));
    end

    // blocked reload, then forced reload at cnt=2
    ld(0, 6, 1'b0, 1'b0);
    rd_ch = 0;
    step();
    ld(0, 4, 1'b0, 1'b0);
    #1 lit("blk_ready", int'(ld_ready), 0);
    for (int k = 0; k < 4; k++) step();
    lit("blk_cnt", int'(rd_count), 2);
    ld_force = 1'b1;
    #1 lit("frc_ready", int'(ld_ready), 1);
    step();
    clr();
    lit("frc_cnt", int'(rd_count), 4);
    for (int k = 1; k <= 4; k++) begin
      step();
      lit("frc_exp", int'(expired[0]), (k == 4) ? 1 : 0);
    end
    lit("frc_act", int'(active[0]), 0);

    // cancel at cnt==1
    ld(0, 3, 1'b0, 1'b0);
    step();
    clr();
    step();
    step();
    lit("can_cnt", int'(rd_count), 1);
    cancel = 3'b001;
    step();
    cancel = '0;
    lit("can_exp", int'(expired[0]), 0);
    lit("can_act", int'(active[0]), 0);
    step();
    lit("can_exp_after", int'(expired[0]), 0);

    // V=0 load stops running ch1
    ld(1, 0, 1'b0, 1'b1);
    rd_ch = 1;
    #1 lit("stop_ready", int'(ld_ready), 1);
    step();
    clr();
    lit("stop_act", int'(active[1]), 0);
    lit("stop_exp", int'(expired[1]), 0);
    lit("stop_cnt", int'(rd_count), 0);
    for (int k = 0; k < 4; k++) step();

    // concurrent ch0 one-shot V=2, ch1 periodic V=2 one edge later
    ld(0, 2, 1'b0, 1'b0);
    step();
    ld(1, 2, 1'b1, 1'b0);
    step();
    clr();
    for (int j = 2; j <= 7; j++) begin
      cancel = (j == 4) ? 3'b001 : 3'b000;
      step();
      lit("cc_exp0", int'(expired[0]), (j == 2) ? 1 : 0);
      lit("cc_exp1", int'(expired[1]), (j % 2 == 1) ? 1 : 0);
      lit("cc_act1", int'(active[1]), 1);
    end
    cancel = 3'b010;
    step();
    cancel = '0;
    lit("cc_stop1", int'(active[1]), 0);

    // out-of-range channel
    ld(3, 7, 1'b1, 1'b0);
    #1 lit("oor_ready", int'(ld_ready), 1);
    step();
    clr();
    lit("oor_act", int'(active), 0);
    rd_ch = 3;
    #1 lit("oor_rd", int'(rd_count), 0);

    // reset mid-count
    rd_ch = 0;
    ld(0, 10, 1'b0, 1'b0);
    step();
    ld(1, 1, 1'b1, 1'b0);
    step();
    clr();
    step();
    lit("v1_exp", int'(expired[1]), 1);
    rst = 1'b1;
    #1 lit("rst_mid_ready", int'(ld_ready), 0);
    step();
    rst = 1'b0;
    lit("rst_mid_act", int'(active), 0);
    lit("rst_mid_exp", int'(expired), 0);
    lit("rst_mid_cnt", int'(rd_count), 0);
    for (int k = 0; k < 12; k++) begin
      step();
      lit("post_rst_exp", int'(expired), 0);
    end

    // maximum period
    ld(0, 255, 1'b0, 1'b0);
    step();
    clr();
    for (int k = 1; k <= 255; k++) begin
      step();
      lit("max_exp", int'(expired[0]), (k == 255) ? 1 : 0);
      if (k == 100) lit("max_cnt", int'(rd_count), 155);
    end
    lit("max_act", int'(active[0]), 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
